// File: rtl/upcounter_sw.sv
// Two-digit BCD up-counting stopwatch with one start/pause button and a
// multiplexed active-low 7-segment display; halts and flags done at LIMIT.
//
// state | meaning
// IDLE  | count cleared to 00, waiting for the first press
// RUN   | prescaler advancing, count increments on each tick
// PAUSE | count and prescaler frozen, press resumes
// DONE  | count held at LIMIT, press returns to IDLE
module upcounter_sw #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_BITS  = 17,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int LIMIT      = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_pause,
    output logic [7:0] D_ssd,
    output logic [3:0] d,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
    localparam logic [3:0]    LIM_TENS  = 4'(LIMIT / 10);
    localparam logic [3:0]    LIM_ONES  = 4'(LIMIT % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic [DW-1:0]   r_deb_cnt;
    logic            r_deb_level;
    logic            r_deb_level_d;
    logic            w_press;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [3:0]      r_ones;
    logic [3:0]      r_tens;
    logic [3:0]      w_ones_nxt;
    logic [3:0]      w_tens_nxt;
    logic [3:0]      w_ones_inc;
    logic [3:0]      w_tens_inc;
    logic            w_tick;
    logic            w_hit_limit;
    logic            r_done;
    logic [SCAN_BITS-1:0] r_scan_cnt;
    logic            w_scan_tick;
    logic            r_sel;
    logic [7:0]      r_seg;
    logic [3:0]      r_dig;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'h03;
            4'd1:    seg7 = 8'h9F;
            4'd2:    seg7 = 8'h25;
            4'd3:    seg7 = 8'h0D;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h49;
            4'd6:    seg7 = 8'h41;
            4'd7:    seg7 = 8'h1F;
            4'd8:    seg7 = 8'h01;
            4'd9:    seg7 = 8'h09;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Level and synchronizers come out of reset as "held", so a button held
    // through reset must be released and pressed again to register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_deb_cnt     <= '0;
            r_deb_level   <= 1'b1;
            r_deb_level_d <= 1'b1;
        end else begin
            r_sync1       <= start_pause;
            r_sync2       <= r_sync1;
            r_deb_level_d <= r_deb_level;
            if (r_sync2 == r_deb_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_MAX) begin
                r_deb_level <= r_sync2;
                r_deb_cnt   <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_deb_level & ~r_deb_level_d;
    assign w_tick  = (r_state == RUN) && (r_presc == PRESC_MAX);

    always_comb begin
        w_ones_inc = r_ones + 4'd1;
        w_tens_inc = r_tens;
        if (r_ones == 4'd9) begin
            w_ones_inc = 4'd0;
            w_tens_inc = r_tens + 4'd1;
        end
        w_hit_limit = (w_tens_inc == LIM_TENS) && (w_ones_inc == LIM_ONES);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_ones_nxt  = r_ones;
        w_tens_nxt  = r_tens;
        case (r_state)
            IDLE: begin
                w_presc_nxt = '0;
                w_ones_nxt  = 4'd0;
                w_tens_nxt  = 4'd0;
                if (w_press) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_tick) begin
                    w_presc_nxt = '0;
                    w_ones_nxt  = w_ones_inc;
                    w_tens_nxt  = w_tens_inc;
                    if (w_hit_limit)  w_state_nxt = DONE;
                    else if (w_press) w_state_nxt = PAUSE;
                end else if (w_press) begin
                    // the press cycle is not charged to the running second
                    w_state_nxt = PAUSE;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            PAUSE: begin
                if (w_press) w_state_nxt = RUN;
            end
            DONE: begin
                w_presc_nxt = '0;
                if (w_press) begin
                    w_state_nxt = IDLE;
                    w_ones_nxt  = 4'd0;
                    w_tens_nxt  = 4'd0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_ones  <= 4'd0;
            r_tens  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_ones  <= w_ones_nxt;
            r_tens  <= w_tens_nxt;
            r_done  <= (r_state == DONE);
        end
    end

    assign w_scan_tick = &r_scan_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_sel      <= 1'b0;
            r_seg      <= 8'hFF;
            r_dig      <= 4'hF;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
            if (w_scan_tick) begin
                r_sel <= ~r_sel;
                if (r_sel) begin
                    r_seg <= seg7(r_tens);
                    r_dig <= 4'b1101;
                end else begin
                    r_seg <= seg7(r_ones);
                    r_dig <= 4'b1110;
                end
            end
        end
    end

    assign D_ssd = r_seg;
    assign d     = r_dig;
    assign done  = r_done;

endmodule

// File: doc/upcounter_sw.md
# upcounter_sw

Two-digit BCD up-counting stopwatch with a single start/pause pushbutton, driving the board's multiplexed 7-segment display. It counts seconds from 00 up to a programmable limit, then halts and flags completion. It complements the team's 30-second down-counter and shares its segment encoding and digit-select convention, so both can share the same display pins. All logic runs on `clk`, using single-cycle enable ticks; no derived clocks are used.

## Interface
- `TICK_DIV`, default 100_000_000: clk cycles per one-second count tick (≥2).
- `SCAN_BITS`, default 17: the digit scan advances every 2^SCAN_BITS clk cycles.
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level (≥2).
- `LIMIT`, default 30: terminal count, BCD-decoded decimal, range 1..99.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start_pause`  in  1  raw pushbutton, active-high, asynchronous to clk.
- `D_ssd`  out  8  segments, active-low; bit7..1 = a..g, bit0 = dp (always 1).
- `d`  out  4  digit enables, active-low; d[0] = ones, d[1] = tens, d[3:2] always 1.
- `done`  out  1  high while in DONE.

## Operation
- Button path:
  - Two-flop synchronizer, then a debouncer. The accepted level changes only after DEB_CYCLES consecutive identical synchronized samples.
  - A rising-edge detector on the accepted level produces `press`, one clk wide.
- FSM states are IDLE, RUN, PAUSE and DONE. Reset enters IDLE.
  - IDLE: count = 00, prescaler = 0. `press` moves to RUN.
  - RUN: prescaler increments every cycle. At TICK_DIV-1 it wraps to 0 and asserts `tick` for one cycle.
    - On `tick`, ones increments. If ones = 9, ones becomes 0 and tens increments.
    - If the post-increment value equals LIMIT, the FSM moves to DONE on the same edge.
    - `press` moves to PAUSE.
  - PAUSE: count and prescaler hold, so the fractional second is preserved. `press` moves to RUN.
  - DONE: count holds at LIMIT and the prescaler is cleared. `press` moves to IDLE, which clears the count to 00.
- Simultaneous `press` and `tick` in RUN: the tick is applied (count increments). The next state is DONE if LIMIT is reached, otherwise PAUSE.
- Count registers are tens[3:0] and ones[3:0], both strictly BCD 0..9. Values never exceed LIMIT.
- Display:
  - A free-running SCAN_BITS counter produces `scan_tick` on wrap. A 1-bit select toggles on each `scan_tick`.
  - On `scan_tick`, the registered outputs load:
    - select 0: `D_ssd` = seg(ones), `d` = 1110.
    - select 1: `D_ssd` = seg(tens), `d` = 1101.
  - Segment codes for 0..9: 03, 9F, 25, 0D, 99, 49, 41, 1F, 01, 09 (hex).
  - Scanning runs in every state.

## Timing
- Reset values: `D_ssd` = FF, `d` = 1111, `done` = 0, select = 0, count = 00, all counters = 0, FSM = IDLE.
- Button latency: an input level that is stable from edge k yields `press` at edge k+2+DEB_CYCLES (±1 cycle). The FSM transitions on that same edge. Bounces shorter than DEB_CYCLES produce no `press`.
- Holding the button produces exactly one `press`. Release produces none.
- First count increment occurs TICK_DIV cycles after entering RUN from IDLE.
- After resuming from PAUSE, the next increment occurs after TICK_DIV minus the cycles already spent in RUN since the last tick.
- `done` is registered: high on the cycle after the DONE transition edge, low on the cycle after leaving DONE.
- Display outputs change only on `scan_tick` edges. The first valid digit appears 2^SCAN_BITS cycles after reset release.
- Reset mid-operation: immediate asynchronous return to reset values in any state. No `press` is generated on release, even if the button is held.

## Test plan
- Test parameters: TICK_DIV=10, SCAN_BITS=2, DEB_CYCLES=4, LIMIT=12.
- Reset, no press, 500 cycles -> count 00, `done`=0, `d` alternates 1110/1101 every 4 cycles, `D_ssd`=03 for both digits.
- One clean press, run 125 cycles -> count passes 09 -> 10 (BCD carry) and reaches 12. FSM enters DONE; `done`=1 one cycle later; count holds at 12 for 200 further cycles.
- Press in RUN at prescaler=6, wait 100 cycles, press again -> count is unchanged during PAUSE; the next increment arrives 4 cycles after resume.
- Bouncy press with 3-cycle glitches, then a stable level -> exactly one `press`. Glitches alone produce no state change.
- Press timed to coincide with `tick` at count 05 -> count 06, state PAUSE. Repeat at count 11 -> count 12, state DONE, `done`=1.
- Assert `rst_n` low mid-RUN with the button held, then release -> all outputs at reset values, FSM IDLE, no `press` until the button is released and pressed again.
